hash_rs: RTL and testbench

// - Reservation station that is the issuing end of the FU input interface of hashfu (and same-shaped FUs).
// - Holds up to DEPTH dispatched instructions and snoops the CDB to resolve source tags.
// - Issues the oldest fully-ready entry as a one-cycle input_transmit pulse whenever the FU reports busy==0.
// - Sits between rename/dispatch and one FU; the FU drives its results to CDB and ROB.

---
 rtl/hash_rs.sv | 205 ++++++++++++++++++++
 tb/tb_hash_rs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_rs.sv
// hash_rs: reservation station on the issuing side of a hashfu-style FU.
// Entries live in a compacting queue (entry 0 is the oldest) and snoop the CDB
// to resolve source tags. The oldest fully-ready entry is issued as a one-cycle
// input_transmit strobe, always followed by at least one idle cycle.
// Optional feature macro: RS_WAKEUP_ISSUE_EN (an entry woken by this cycle's
// CDB broadcast may be selected in the same cycle, using cdb_val directly).
module hash_rs #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [7:0]                   disp_operand,
    input  logic [1:0]                   disp_src_rdy,
    input  logic [1:0][TAG_W-1:0]        disp_src_tag,
    input  logic [1:0][DATA_W-1:0]       disp_src_val,
    input  logic [7:0]                   disp_wbs,
    input  logic [7:0]                   disp_flags,
    input  logic [TAG_W-1:0]             disp_robid,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_id,
    input  logic [DATA_W-1:0]            cdb_val,
    input  logic                         fu_busy,
    output logic                         input_transmit,
    output logic [7:0]                   operand,
    output logic [1:0][DATA_W-1:0]       depvals,
    output logic [7:0]                   wbs,
    output logic [7:0]                   flags,
    output logic [TAG_W-1:0]             robid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0]             op;
        logic [1:0]             rdy;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0][DATA_W-1:0] val;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [TAG_W-1:0]       robid;
    } entry_t;

    // Resolve any waiting source of an entry whose tag matches the broadcast.
    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] id,
                                    input logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        for (int s = 0; s < 2; s++) begin
            if (v && !e.rdy[s] && (e.tag[s] == id)) begin
                r.rdy[s] = 1'b1;
                r.val[s] = d;
            end else begin
                r.rdy[s] = e.rdy[s];
            end
        end
        return r;
    endfunction

    entry_t                 r_q [DEPTH];
    logic [CW-1:0]          r_count;
    logic                   r_xmit;
    logic [7:0]             r_operand;
    logic [1:0][DATA_W-1:0] r_depvals;
    logic [7:0]             r_wbs;
    logic [7:0]             r_flags;
    logic [TAG_W-1:0]       r_robid;

    entry_t                 w_ext [DEPTH+1];
    entry_t                 w_disp_raw;
    entry_t                 w_disp;
    entry_t                 w_next [DEPTH];
    logic [DEPTH-1:0]       w_cand;
    logic                   w_found;
    logic [CW-1:0]          w_sel;
    logic [7:0]             w_sel_op;
    logic [1:0][DATA_W-1:0] w_sel_dep;
    logic [7:0]             w_sel_wbs;
    logic [7:0]             w_sel_flags;
    logic [TAG_W-1:0]       w_sel_robid;
    logic                   w_issue;
    logic                   w_disp_fire;
    logic [CW-1:0]          w_base;
    logic [CW-1:0]          w_count_next;

    assign disp_ready     = (r_count < CW'(DEPTH));
    assign input_transmit = r_xmit;
    assign operand        = r_operand;
    assign depvals        = r_depvals;
    assign wbs            = r_wbs;
    assign flags          = r_flags;
    assign robid          = r_robid;
    assign count          = r_count;

    // Apply this cycle's CDB broadcast to stored entries and to the incoming dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = wake(r_q[i], cdb_valid, cdb_id, cdb_val);
        end
        w_ext[DEPTH]     = '0;
        w_disp_raw       = '0;
        w_disp_raw.op    = disp_operand;
        w_disp_raw.rdy   = disp_src_rdy;
        w_disp_raw.tag   = disp_src_tag;
        w_disp_raw.val   = disp_src_val;
        w_disp_raw.wbs   = disp_wbs;
        w_disp_raw.flags = disp_flags;
        w_disp_raw.robid = disp_robid;
        w_disp           = wake(w_disp_raw, cdb_valid, cdb_id, cdb_val);
    end

    // Pick the oldest ready entry and decide whether it issues this cycle
    always_comb begin
        w_cand      = '0;
        w_found     = 1'b0;
        w_sel       = '0;
        w_sel_op    = '0;
        w_sel_dep   = '0;
        w_sel_wbs   = '0;
        w_sel_flags = '0;
        w_sel_robid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 32'(r_count)) begin
`ifdef RS_WAKEUP_ISSUE_EN
                w_cand[i] = &w_ext[i].rdy;
`else
                w_cand[i] = &r_q[i].rdy;
`endif
            end else begin
                w_cand[i] = 1'b0;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found     = 1'b1;
                w_sel       = CW'(i);
                w_sel_op    = w_ext[i].op;
                w_sel_dep   = w_ext[i].val;
                w_sel_wbs   = w_ext[i].wbs;
                w_sel_flags = w_ext[i].flags;
                w_sel_robid = w_ext[i].robid;
            end else begin
                w_found = w_found;
            end
        end
        w_issue     = ~fu_busy & w_found & ~r_xmit;
        w_disp_fire = disp_valid & disp_ready;
    end

    // Compact the queue around the issued slot and append the dispatch at the new tail
    always_comb begin
        w_base       = r_count - {{(CW-1){1'b0}}, w_issue};
        w_count_next = w_base + {{(CW-1){1'b0}}, w_disp_fire};
        for (int j = 0; j < DEPTH; j++) begin
            if (w_disp_fire && (CW'(j) == w_base)) begin
                w_next[j] = w_disp;
            end else if (CW'(j) < w_base) begin
                w_next[j] = (w_issue && (CW'(j) >= w_sel)) ? w_ext[j+1] : w_ext[j];
            end else begin
                w_next[j] = '0;
            end
        end
    end

    // Queue storage and occupancy; reset and flush discard every entry
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end

    // Issue strobe and issued fields; fields hold their value between strobes
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_xmit    <= 1'b0;
            r_operand <= '0;
            r_depvals <= '0;
            r_wbs     <= '0;
            r_flags   <= '0;
            r_robid   <= '0;
        end else begin
            r_xmit <= w_issue;
            if (w_issue) begin
                r_operand <= w_sel_op;
                r_depvals <= w_sel_dep;
                r_wbs     <= w_sel_wbs;
                r_flags   <= w_sel_flags;
                r_robid   <= w_sel_robid;
            end
        end
    end
endmodule

// File: tb/tb_hash_rs.sv
// Self-checking bench for hash_rs: a queue-based reference model checked on
// every cycle, plus directed scenarios with literal expectations.
// Honors RS_WAKEUP_ISSUE_EN in the same way as the design.
module tb_hash_rs;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;
`ifdef RS_WAKEUP_ISSUE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst, flush, disp_valid, disp_ready;
    logic [7:0]             disp_operand, disp_wbs, disp_flags;
    logic [1:0]             disp_src_rdy;
    logic [1:0][TAG_W-1:0]  disp_src_tag;
    logic [1:0][DATA_W-1:0] disp_src_val;
    logic [TAG_W-1:0]       disp_robid, cdb_id, robid;
    logic                   cdb_valid, fu_busy, input_transmit;
    logic [DATA_W-1:0]      cdb_val;
    logic [7:0]             operand, wbs, flags;
    logic [1:0][DATA_W-1:0] depvals;
    logic [2:0]             count;

    hash_rs #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
        .disp_ready(disp_ready), .disp_operand(disp_operand),
        .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag),
        .disp_src_val(disp_src_val), .disp_wbs(disp_wbs), .disp_flags(disp_flags),
        .disp_robid(disp_robid), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .fu_busy(fu_busy), .input_transmit(input_transmit),
        .operand(operand), .depvals(depvals), .wbs(wbs), .flags(flags),
        .robid(robid), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]             op;
        logic [1:0]             rdy;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0][DATA_W-1:0] val;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [TAG_W-1:0]       robid;
    } ins_t;

    ins_t             m_q[$];
    logic             e_xmit;
    logic [7:0]       e_op, e_wbs, e_flags;
    logic [15:0]      e_dep;
    logic [TAG_W-1:0] e_robid;
    bit               started = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [TAG_W-1:0] log_rid[$];
    logic [15:0]      log_dep[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model helper: a source counts as present once resolved by any broadcast
    function automatic ins_t snoop(input ins_t e);
        ins_t r;
        r = e;
        for (int s = 0; s < 2; s++) begin
            if (cdb_valid && !e.rdy[s] && e.tag[s] == cdb_id) begin
                r.rdy[s] = 1'b1;
                r.val[s] = cdb_val;
            end
        end
        return r;
    endfunction

    function automatic bit ready_now(input ins_t e);
        ins_t w;
        w = snoop(e);
        return EN ? (w.rdy == 2'b11) : (e.rdy == 2'b11);
    endfunction

    // Reference model: oldest-ready issue, one idle cycle between strobes, tail append
    always @(posedge clk) begin : model
        int   sel;
        bit   iss, acc;
        ins_t n;
        if (rst || flush) begin
            m_q.delete();
            e_xmit = 1'b0; e_op = 8'h00; e_wbs = 8'h00; e_flags = 8'h00;
            e_dep = 16'h0000; e_robid = '0;
        end else begin
            acc = disp_valid && (m_q.size() < DEPTH);
            sel = -1;
            foreach (m_q[i]) if (sel < 0 && ready_now(m_q[i])) sel = i;
            iss = !fu_busy && (sel >= 0) && !e_xmit;
            foreach (m_q[i]) m_q[i] = snoop(m_q[i]);
            if (iss) begin
                e_op = m_q[sel].op; e_dep = m_q[sel].val; e_wbs = m_q[sel].wbs;
                e_flags = m_q[sel].flags; e_robid = m_q[sel].robid;
                m_q.delete(sel);
            end
            e_xmit = iss;
            if (acc) begin
                n.op = disp_operand; n.rdy = disp_src_rdy; n.tag = disp_src_tag;
                n.val = disp_src_val; n.wbs = disp_wbs; n.flags = disp_flags;
                n.robid = disp_robid;
                m_q.push_back(snoop(n));
            end
        end
        started = 1'b1;
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            check("xmit", {31'd0, input_transmit}, {31'd0, e_xmit});
            check("count", {29'd0, count}, m_q.size());
            check("disp_ready", {31'd0, disp_ready}, {31'd0, m_q.size() < DEPTH});
            check("operand", {24'd0, operand}, {24'd0, e_op});
            check("depvals", {16'd0, depvals}, {16'd0, e_dep});
            check("wbs", {24'd0, wbs}, {24'd0, e_wbs});
            check("flags", {24'd0, flags}, {24'd0, e_flags});
            check("robid", {28'd0, robid}, {28'd0, e_robid});
            if (input_transmit) begin
                log_rid.push_back(robid);
                log_dep.push_back(depvals);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic put(input logic [3:0] rid, input logic [1:0] rdy,
                       input logic [3:0] t0, input logic [3:0] t1,
                       input logic [7:0] v0, input logic [7:0] v1);
        disp_valid = 1'b1; disp_robid = rid; disp_src_rdy = rdy;
        disp_src_tag[0] = t0; disp_src_tag[1] = t1;
        disp_src_val[0] = v0; disp_src_val[1] = v1;
        disp_operand = 8'h40 + {4'h0, rid}; disp_wbs = 8'hC0 + {4'h0, rid};
        disp_flags = {4'h0, rid};
    endtask

    task automatic cdb(input logic [3:0] id, input logic [7:0] v);
        cdb_valid = 1'b1; cdb_id = id; cdb_val = v;
    endtask

    task automatic check_log(input string name, input int k,
                             input logic [3:0] rid, input logic [15:0] dep);
        if (log_rid.size() > k) begin
            check({name, "_rid"}, {28'd0, log_rid[k]}, {28'd0, rid});
            check({name, "_dep"}, {16'd0, log_dep[k]}, {16'd0, dep});
        end else begin
            check({name, "_present"}, log_rid.size(), k + 1);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; fu_busy = 1'b0;
        cdb_id = '0; cdb_val = '0; disp_operand = '0; disp_wbs = '0; disp_flags = '0;
        disp_src_rdy = '0; disp_src_tag = '0; disp_src_val = '0; disp_robid = '0;
        step(2);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_ready", {31'd0, disp_ready}, 32'd1);
        check("rst_xmit", {31'd0, input_transmit}, 32'd0);
        check("rst_robid", {28'd0, robid}, 32'd0);
        rst = 1'b0;
        step(1);

        // Ready instruction on an idle RS: strobe one cycle after acceptance
        put(4'd1, 2'b11, 4'd0, 4'd0, 8'h12, 8'h00);
        step(1); idle();
        check("t1_count", {29'd0, count}, 32'd1);
        check("t1_early", {31'd0, input_transmit}, 32'd0);
        step(1);
        check("t1_xmit", {31'd0, input_transmit}, 32'd1);
        check("t1_dep0", {24'd0, depvals[0]}, 32'h12);
        check("t1_robid", {28'd0, robid}, 32'd1);
        check("t1_wbs", {24'd0, wbs}, 32'hC1);
        step(1);
        check("t1_pulse_end", {31'd0, input_transmit}, 32'd0);

        // Waiting source resolved by a later broadcast
        log_rid.delete(); log_dep.delete();
        put(4'd2, 2'b10, 4'd5, 4'd0, 8'h00, 8'h00);
        step(1); idle(); step(1);
        cdb(4'd5, 8'hA5);
        step(1); idle();
        check("t2_first", {31'd0, input_transmit}, {31'd0, EN});
        step(1);
        check("t2_second", {31'd0, input_transmit}, {31'd0, !EN});
        step(3);
        check_log("t2", 0, 4'd2, 16'h00A5);

        // Fill while FU busy, extra dispatch ignored, then in-order drain
        fu_busy = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            put(4'(r), 2'b11, 4'd0, 4'd0, 8'(r * 17), 8'h00);
            step(1);
        end
        put(4'd5, 2'b11, 4'd0, 4'd0, 8'h55, 8'h00);
        step(1);
        check("t3_full_ready", {31'd0, disp_ready}, 32'd0);
        check("t3_full_count", {29'd0, count}, 32'd4);
        step(1);
        idle(); fu_busy = 1'b0;
        log_rid.delete(); log_dep.delete();
        step(12);
        check("t3_issues", log_rid.size(), 32'd4);
        check_log("t3_0", 0, 4'd1, 16'h0011);
        check_log("t3_1", 1, 4'd2, 16'h0022);
        check_log("t3_2", 2, 4'd3, 16'h0033);
        check_log("t3_3", 3, 4'd4, 16'h0044);

        // Younger ready entry bypasses an older waiting one
        log_rid.delete(); log_dep.delete();
        put(4'd1, 2'b10, 4'd7, 4'd0, 8'h00, 8'h00);
        step(1);
        put(4'd2, 2'b11, 4'd0, 4'd0, 8'h22, 8'h00);
        step(1); idle(); step(4);
        cdb(4'd7, 8'h77);
        step(1); idle(); step(5);
        check_log("t4_0", 0, 4'd2, 16'h0022);
        check_log("t4_1", 1, 4'd1, 16'h0077);

        // Wakeup during dispatch, and both sources from one broadcast
        log_rid.delete(); log_dep.delete();
        put(4'd3, 2'b10, 4'd3, 4'd0, 8'h00, 8'h00);
        cdb(4'd3, 8'hFF);
        step(1); idle(); step(4);
        put(4'd8, 2'b00, 4'd9, 4'd9, 8'h00, 8'h00);
        step(1); idle(); step(1);
        cdb(4'd9, 8'h5A);
        step(1); idle(); step(4);
        check_log("t5_0", 0, 4'd3, 16'h00FF);
        check_log("t5_1", 1, 4'd8, 16'h5A5A);

        // Flush with three entries and a dispatch pending in the same cycle
        fu_busy = 1'b1;
        for (int r = 4; r <= 6; r++) begin
            put(4'(r), 2'b11, 4'd0, 4'd0, 8'h66, 8'h00);
            step(1);
        end
        check("t6_pre_count", {29'd0, count}, 32'd3);
        put(4'd7, 2'b11, 4'd0, 4'd0, 8'h77, 8'h00);
        flush = 1'b1;
        step(1); idle();
        check("t6_count", {29'd0, count}, 32'd0);
        check("t6_ready", {31'd0, disp_ready}, 32'd1);
        check("t6_xmit", {31'd0, input_transmit}, 32'd0);
        check("t6_robid", {28'd0, robid}, 32'd0);
        fu_busy = 1'b0;
        log_rid.delete(); log_dep.delete();
        step(6);
        check("t6_no_issue", log_rid.size(), 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
